// File: rtl/demux_defs.sv
// rtl/demux_defs.sv - shared widths and FSM encodings for the bit8 demux deserializer
package demux_defs;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;
endpackage

// File: rtl/bit8_demux_1to8.sv
// rtl/bit8_demux_1to8.sv - 1-to-8 one-hot write-enable decoder
module bit8_demux_1to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] we
);
  always_comb begin
    we      = 8'h00;
    we[sel] = en;
  end
endmodule

// File: rtl/bit8_demux_deserializer.sv
// rtl/bit8_demux_deserializer.sv - LSB-first serial-to-parallel word assembler with ready/valid output
import demux_defs::*;

module bit8_demux_deserializer #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              z,
  input  logic              z_valid,
  output logic [SEL_W-1:0]  s,
  output logic [DATA_W-1:0] i,
  output logic              i_valid,
  input  logic              i_ready,
  output logic              busy,
  output logic              overrun
);
  logic [0:0]        state;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] we;
  logic              accept;
  logic              complete;
  logic              handshake;

  // start wins over a bit arriving in the same cycle
  assign accept    = (state == ST_COLLECT) && z_valid && !start;
  assign complete  = accept && (s == SEL_W'(DATA_W - 1));
  assign handshake = i_valid && i_ready;

  bit8_demux_1to8 u_demux (
    .en  (accept),
    .sel (s),
    .we  (we)
  );

  // includes the bit accepted this cycle so completion can load the full word
  assign asm_next = (asm_q & ~we) | ({DATA_W{z}} & we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      s       <= '0;
      asm_q   <= '0;
      i       <= '0;
      i_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (handshake) begin
        i_valid <= 1'b0;
      end
      if (start) begin
        state   <= ST_COLLECT;
        busy    <= 1'b1;
        s       <= '0;
        asm_q   <= '0;
        overrun <= 1'b0;
      end else if (accept) begin
        s <= s + 1'b1;
        if (complete) begin
          asm_q <= '0;
          // a pending unconsumed word is kept; the new one is dropped
          if (!i_valid || i_ready) begin
            i       <= asm_next;
            i_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          asm_q <= asm_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit8_demux_deserializer.sv
// tb/tb_bit8_demux_deserializer.sv - directed self-checking bench for bit8_demux_deserializer
module tb_bit8_demux_deserializer;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       z;
  logic       z_valid;
  logic [2:0] s;
  logic [7:0] i;
  logic       i_valid;
  logic       i_ready;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  bit8_demux_deserializer #(.DATA_W(8), .SEL_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .z       (z),
    .z_valid (z_valid),
    .s       (s),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    z       = b;
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) send_bit(w[k]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] s_hold;
    rst_n = 1'b0; start = 1'b0; z = 1'b0; z_valid = 1'b0; i_ready = 1'b0;
    tick();
    check("rst_s", s, 0);
    check("rst_i", i, 0);
    check("rst_i_valid", i_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // basic frame 0xCC, consumer always ready
    rst_n = 1'b1;
    i_ready = 1'b1;
    do_start();
    check("start_busy", busy, 1);
    check("start_s", s, 0);
    send_bits(8'hCC, 3);
    check("mid_s3", s, 3);
    check("mid_no_valid", i_valid, 0);
    z = 1'b1; z_valid = 1'b1;
    for (int k = 3; k < 8; k++) begin
      z = k[2] ? 1'b1 : 1'b0;
      z = (8'hCC >> k) & 8'h01;
      tick();
    end
    z_valid = 1'b0;
    check("cc_i", i, 8'hCC);
    check("cc_i_valid", i_valid, 1);
    check("cc_s_wrap", s, 0);
    check("cc_busy", busy, 1);
    tick();
    check("cc_valid_1cyc", i_valid, 0);

    // same frame with a gap cycle after each bit
    for (int k = 0; k < 8; k++) begin
      z = (8'hCC >> k) & 8'h01; z_valid = 1'b1;
      tick();
      z_valid = 1'b0; s_hold = s;
      z = ~z;
      if (k == 7) begin
        check("gap_i", i, 8'hCC);
        check("gap_i_valid", i_valid, 1);
      end
      tick();
      if (k < 7) check("gap_s_hold", s, s_hold);
    end
    check("gap_consumed", i_valid, 0);

    // overrun: consumer stalled across two frames
    i_ready = 1'b0;
    send_bits(8'hCC, 8);
    check("ovr_first_i", i, 8'hCC);
    check("ovr_first_flag", overrun, 0);
    send_bits(8'h5A, 8);
    check("ovr_i_kept", i, 8'hCC);
    check("ovr_i_valid", i_valid, 1);
    check("ovr_flag", overrun, 1);
    do_start();
    check("ovr_cleared", overrun, 0);
    check("ovr_start_i", i, 8'hCC);
    check("ovr_start_valid", i_valid, 1);
    i_ready = 1'b1;
    tick();
    check("ovr_drain", i_valid, 0);

    // resync: partial frame abandoned, start beats a simultaneous bit
    send_bits(8'hFF, 4);
    check("rs_s4", s, 4);
    z = 1'b1; z_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; z_valid = 1'b0;
    check("rs_s0", s, 0);
    send_bits(8'hA5, 8);
    check("rs_i", i, 8'hA5);
    check("rs_i_valid", i_valid, 1);
    tick();

    // reset mid-frame at s=5
    do_start();
    send_bits(8'h1F, 5);
    check("rm_s5", s, 5);
    rst_n = 1'b0; z = 1'b1; z_valid = 1'b1; i_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rm_s", s, 0);
    check("rm_i", i, 0);
    check("rm_i_valid", i_valid, 0);
    check("rm_busy", busy, 0);
    for (int k = 0; k < 3; k++) tick();
    z_valid = 1'b0;
    check("rm_idle_s", s, 0);
    check("rm_idle_busy", busy, 0);

    // completion coincident with a handshake
    do_start();
    send_bits(8'hCC, 8);
    check("co_first", i, 8'hCC);
    send_bits(8'h5A, 7);
    check("co_hold", i, 8'hCC);
    i_ready = 1'b1;
    send_bit(1'b0);
    check("co_i", i, 8'h5A);
    check("co_i_valid", i_valid, 1);
    check("co_overrun", overrun, 0);
    tick();
    check("co_drain", i_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bit8_demux_deserializer.md
BIT8_DEMUX_DESERIALIZER -- requirements
Module: bit8_demux_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the parallel word width; only the value 8 is supported.
REQ-002 SHALL have parameter SEL_W, default 3, meaning the slot-select width, log2(DATA_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: begin or resynchronise a frame.
REQ-006 SHALL have port z, input, 1 bit: serial data bit (the mux output Z being demultiplexed).
REQ-007 SHALL have port z_valid, input, 1 bit: z is valid this cycle.
REQ-008 SHALL have port s, output, SEL_W bits: slot index the next accepted bit is written to.
REQ-009 SHALL have port i, output, DATA_W bits: last completed parallel word.
REQ-010 SHALL have port i_valid, output, 1 bit: i holds an unconsumed word.
REQ-011 SHALL have port i_ready, input, 1 bit: consumer accepts i when i_valid and i_ready are both high.
REQ-012 SHALL have port busy, output, 1 bit: high in COLLECT.
REQ-013 SHALL have port overrun, output, 1 bit: sticky; a completed word was dropped.

Function
REQ-014 SHALL implement FSM states IDLE and COLLECT.
REQ-015 IDLE -> COLLECT SHALL occur on start=1; s SHALL be cleared to 0 and the assembly register cleared; z_valid SHALL be ignored in IDLE.
REQ-016 In COLLECT, a bit SHALL be accepted on a cycle with z_valid=1; z SHALL be written to assembly bit position s, and s SHALL increment by 1.
REQ-017 Bit order SHALL be LSB-first: the first accepted bit lands in i[0] and the eighth in i[7], matching mux select s selecting i[s].
REQ-018 Acceptance of the bit at s=7 SHALL complete the word; s SHALL wrap to 0 and the FSM SHALL remain in COLLECT for back-to-back frames.
REQ-019 On completion, the assembled word, including the bit accepted that cycle, SHALL load into i with i_valid=1 on the next clock edge (1-cycle latency).
REQ-020 i and i_valid SHALL hold stable while i_valid=1 and i_ready=0; a handshake SHALL clear i_valid on the next edge.
REQ-021 If a word completes while i_valid=1 and i_ready=0, the new word SHALL be dropped, i SHALL be unchanged, and overrun SHALL be set.
REQ-022 If completion coincides with a handshake, the new word SHALL load and i_valid SHALL stay 1, with no overrun.
REQ-023 start=1 in COLLECT SHALL discard partial bits and set s=0; start SHALL take priority over a simultaneous z_valid bit.
REQ-024 start SHALL clear overrun; start SHALL NOT affect i or i_valid.
REQ-025 z_valid=0 cycles SHALL leave s and the assembly register unchanged (gaps allowed).

Reset
REQ-026 rst_n=0 sampled on a rising clk edge SHALL force state=IDLE, s=0, i=8'h00, i_valid=0, busy=0, overrun=0, and clear the assembly register.
REQ-027 Reset SHALL override start, z_valid and i_ready in the same cycle, including mid-frame.
REQ-028 No output SHALL change asynchronously with rst_n.

Structure
REQ-029 DATA_W, SEL_W and the state encodings (IDLE=1'b0, COLLECT=1'b1) SHALL live in a shared package/include, demux_defs.
REQ-030 A combinational sub-module bit8_demux_1to8 (inputs en and sel[2:0], output one-hot we[7:0]) SHALL generate the assembly-register write enables.
REQ-031 All outputs SHALL be driven directly from registers.

Verification
REQ-032 The bench SHALL cover: reset, start, then bits 0,0,1,1,0,0,1,1 with z_valid=1 for 8 cycles and i_ready=1 -> i=8'hCC with i_valid for 1 cycle, one cycle after the 8th bit, and s back to 0.
REQ-033 The bench SHALL cover: the same frame with z_valid toggling 1/0 -> i=8'hCC after 16 cycles, with s constant during gap cycles.
REQ-034 The bench SHALL cover: i_ready=0, then two frames 8'hCC and 8'h5A -> i stays 8'hCC and overrun=1; a following start gives overrun=0.
REQ-035 The bench SHALL cover: 4 bits, then start with z_valid=1, then 8 bits of 8'hA5 -> i=8'hA5, with no partial-frame corruption.
REQ-036 The bench SHALL cover: rst_n=0 at s=5 mid-frame -> next edge gives s=0, i=0, i_valid=0, busy=0, and z_valid is ignored until start.
REQ-037 The bench SHALL cover: frame completion in the same cycle as an i_valid/i_ready handshake -> new word loaded, i_valid remains 1, overrun=0.
